if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, computes PC+4, issues
//  instruction-memory reads over a req/gnt/rvalid handshake and loads the IF/ID register
//  (instr, pc+4). It consumes the branch/jump target from the ID stage and redirects the fetch.
//  It handles stalls with a one-entry buffer and flushes the wrong-path instruction on redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous reset, active-low
//  stall        in   1   hazard unit: hold IF/ID contents
//  br_taken     in   1   ID stage: redirect valid this cycle (branch or jump)
//  br_target    in   32  ID stage: redirect address; bits [1:0] are ignored and forced to 0
//  imem_req     out  1   read request valid
//  imem_addr    out  32  read address (equal to pc while imem_req is high)
//  imem_gnt     in   1   memory accepts the request this cycle
//  imem_rvalid  in   1   read data valid; at least 1 cycle after gnt
//  imem_rdata   in   32  instruction word
//  pc           out  32  next fetch address
//  ifid_valid   out  1   IF/ID holds a valid instruction
//  ifid_instr   out  32  IF/ID instruction
//  ifid_pc4     out  32  IF/ID address of the instruction + 4
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC; ifid_valid=0, ifid_instr=0, ifid_pc4=0; imem_req=0.
//   - FSM goes to S_REQ, the buffer is empty and kill=0.
//   - imem_req rises on the first clk edge after rst_n deasserts.
//  FSM states:
//   - S_REQ: imem_req=1 and imem_addr=pc. On imem_gnt: save inflight_pc4=pc+4, set pc<=pc+4, go to S_WAIT.
//   - S_WAIT: imem_req=0. On imem_rvalid, deliver the word (see below), then go to S_REQ,
//     or to S_FULL if the word went into the buffer.
//   - S_FULL: imem_req=0 and the buffer is valid. When stall=0, move the buffer into IF/ID and go to S_REQ.
//   - Only one request is outstanding at a time, so there is no new request while S_WAIT or S_FULL.
//  Delivery of rvalid (if kill=1, the word is dropped, kill clears and there is no IF/ID change from it):
//   - stall=0: ifid_valid<=1, ifid_instr<=imem_rdata, ifid_pc4<=inflight_pc4.
//   - stall=1: the word and pc4 go into the buffer; IF/ID is held.
//  IF/ID with no delivery and stall=0: ifid_valid<=0 (bubble). instr and pc4 are held.
//  IF/ID with stall=1: all ifid_* are held.
//  Redirect (br_taken=1, highest priority, overrides stall):
//   - pc<=br_target&~3 and ifid_valid<=0.
//   - The buffer is cleared. From S_FULL, go to S_REQ.
//   - In S_WAIT with no rvalid this cycle: kill<=1 so the pending response is dropped.
//   - rvalid in the same cycle: that word is dropped. Go to S_REQ.
//   - S_REQ with gnt in the same cycle: the request is granted, kill<=1 and the FSM goes to S_WAIT.
//     pc takes the target, not pc+4.
//  Arithmetic: all +4 is modulo 2^32. 32'hFFFF_FFFC+4 = 32'h0, with no flag.
//  Latency: the first instruction reaches IF/ID 3 cycles after rst_n rises if gnt and rvalid
//   each arrive in the minimum time. Throughput is 1 instruction per 2 cycles at minimum memory latency.
//  br_taken while ifid_valid=0 or while stalled is legal and follows the same rules.
// TESTING
//  1 Reset RESET_PC=0, memory with gnt same cycle and rvalid 1 cycle later -> addresses 0,4,8 appear.
//    IF/ID shows pc4 4,8,C with matching instrs.
//  2 Assert stall as rvalid returns the word for addr 8 -> the word for 8 is buffered and imem_req stays 0.
//    IF/ID holds pc4=8; after stall drops, ifid_pc4=C next edge.
//  3 br_taken=1 with target 0x0000_0103 while in S_WAIT for addr 0x10 -> that response is dropped and ifid_valid=0.
//    The next imem_addr is 0x100, then IF/ID pc4=0x104.
//  4 br_taken and imem_rvalid in the same cycle, with stall=1 -> the word is dropped and ifid_valid=0 despite stall.
//    pc=target.
//  5 RESET_PC=32'hFFFF_FFFC -> the first address is FFFF_FFFC with ifid_pc4=0, and the next address is 0.
//  6 Pulse rst_n low mid-S_WAIT -> all outputs return to their reset values at once.
//    A late rvalid is ignored and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline.
// It owns the PC and issues one instruction-memory read at a time over a req/gnt/rvalid handshake.
// Returned words load the IF/ID register, or a one-entry buffer while the pipeline is stalled.
// A redirect from ID overrides everything and discards any wrong-path response still in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  // Sequential address step; wraps silently at the top of the address space.
  function automatic logic [31:0] add4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  // run holds imem_req low for the first cycle out of reset.
  logic        run;
  // kill marks the single outstanding response as wrong-path.
  logic        kill;
  logic        buf_valid;
  logic [31:0] inflight_pc4;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;

  logic        granted;
  logic        resp;
  logic        deliver;
  logic        to_ifid;
  logic        to_buf;
  logic        drain;

  assign imem_req  = run && (state == S_REQ);
  assign imem_addr = pc;

  assign granted = imem_req && imem_gnt;
  assign resp    = (state == S_WAIT) && imem_rvalid;
  // A response is only useful if it is on the correct path and not overtaken by a redirect.
  assign deliver = resp && !kill && !br_taken;
  assign to_ifid = deliver && !stall;
  assign to_buf  = deliver && stall;
  assign drain   = (state == S_FULL) && buf_valid && !stall && !br_taken;

  // Next-state decode for the one-outstanding-request fetch sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (granted) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (resp) state_nxt = to_buf ? S_FULL : S_REQ;
      end
      S_FULL: begin
        if (br_taken || !stall) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Sequencer control: state, start-up gate and wrong-path kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      run   <= 1'b0;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (resp) begin
        kill <= 1'b0;
      end else if (br_taken && ((state == S_WAIT) || granted)) begin
        kill <= 1'b1;
      end
    end
  end

  // Program counter: redirect wins over the sequential step on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= align(RESET_PC);
    end else if (br_taken) begin
      pc <= align(br_target);
    end else if (granted) begin
      pc <= add4(pc);
    end
  end

  // Skid buffer occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (br_taken) begin
      buf_valid <= 1'b0;
    end else if (to_buf) begin
      buf_valid <= 1'b1;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // Datapath holding registers; their contents only matter while qualified by control state.
  always_ff @(posedge clk) begin
    if (granted) begin
      inflight_pc4 <= add4(pc);
    end
    if (to_buf) begin
      buf_instr <= imem_rdata;
      buf_pc4   <= inflight_pc4;
    end
  end

  // IF/ID register: redirect flushes, stall holds, otherwise load a word or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else if (br_taken) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (to_ifid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= imem_rdata;
        ifid_pc4   <= inflight_pc4;
      end else if (drain) begin
        ifid_valid <= 1'b1;
        ifid_instr <= buf_instr;
        ifid_pc4   <= buf_pc4;
      end else begin
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: main instance at RESET_PC=0 plus a second
// instance at RESET_PC=FFFF_FFFC for address wrap. Memory returns {16'hC0DE, addr[15:0]}.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  logic        rst2_n;
  logic        stall2;
  logic        br2;
  logic [31:0] tgt2;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic        v2;
  logic [31:0] instr2;
  logic [31:0] pc4_2;

  // Memory model state: slow=1 adds one cycle of read latency.
  logic        slow;
  logic        m_rv1, m_rv2;
  logic [31:0] m_d1, m_d2;
  logic        m2_rv;
  logic [31:0] m2_d;

  int checks;
  int failures;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(stall2), .br_taken(br2), .br_target(tgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .pc(pc2),
    .ifid_valid(v2), .ifid_instr(instr2), .ifid_pc4(pc4_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant in the same cycle as the request; data one (or two) cycles later.
  assign imem_gnt    = imem_req;
  assign imem_rvalid = slow ? m_rv2 : m_rv1;
  assign imem_rdata  = slow ? m_d2 : m_d1;
  always @(posedge clk) begin
    m_rv1 <= imem_req && imem_gnt;
    m_d1  <= {16'hC0DE, imem_addr[15:0]};
    m_rv2 <= m_rv1;
    m_d2  <= m_d1;
  end

  assign gnt2    = req2;
  assign rvalid2 = m2_rv;
  assign rdata2  = m2_d;
  always @(posedge clk) begin
    m2_rv <= req2 && gnt2;
    m2_d  <= {16'hC0DE, addr2[15:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; slow = 1'b0;
    rst2_n = 1'b0; stall2 = 1'b0; br2 = 1'b0; tgt2 = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 00000000", pc); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 00000000", ifid_instr); end
    checks++; if (ifid_pc4 !== 32'h0) begin failures++; $display("FAIL rst_pc4: got %h want 00000000", ifid_pc4); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    tick(); // E1: request for 0 appears
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL e1_req_addr: got %b/%h want 1/00000000", imem_req, imem_addr); end
    tick(); // E2: granted
    checks++; if ({imem_req, pc} !== {1'b0, 32'h4}) begin failures++; $display("FAIL e2_req_pc: got %b/%h want 0/00000004", imem_req, pc); end
    tick(); // E3: first instruction in IF/ID
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h4, 32'hC0DE_0000}) begin failures++; $display("FAIL e3_ifid: got %b/%h/%h want 1/00000004/c0de0000", ifid_valid, ifid_pc4, ifid_instr); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL e3_req_addr: got %b/%h want 1/00000004", imem_req, imem_addr); end
    tick(); // E4: bubble
    checks++; if ({ifid_valid, pc} !== {1'b0, 32'h8}) begin failures++; $display("FAIL e4_bubble_pc: got %b/%h want 0/00000008", ifid_valid, pc); end
    tick(); // E5
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h8, 32'hC0DE_0004}) begin failures++; $display("FAIL e5_ifid: got %b/%h/%h want 1/00000008/c0de0004", ifid_valid, ifid_pc4, ifid_instr); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL e5_addr: got %h want 00000008", imem_addr); end
    tick(); // E6: grant for 8
    checks++; if ({ifid_valid, ifid_pc4} !== {1'b0, 32'h8}) begin failures++; $display("FAIL e6_bubble: got %b/%h want 0/00000008", ifid_valid, ifid_pc4); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick(); // E7: word for 8 goes to buffer
    checks++; if ({imem_req, ifid_valid, ifid_pc4} !== {1'b0, 1'b0, 32'h8}) begin failures++; $display("FAIL st_buffered: got %b/%b/%h want 0/0/00000008", imem_req, ifid_valid, ifid_pc4); end
    tick(); // E8: still stalled
    checks++; if ({imem_req, ifid_pc4} !== {1'b0, 32'h8}) begin failures++; $display("FAIL st_hold: got %b/%h want 0/00000008", imem_req, ifid_pc4); end
    stall = 1'b0;
    tick(); // E9: buffer drains
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'hC, 32'hC0DE_0008}) begin failures++; $display("FAIL st_drain: got %b/%h/%h want 1/0000000c/c0de0008", ifid_valid, ifid_pc4, ifid_instr); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin failures++; $display("FAIL st_next_req: got %b/%h want 1/0000000c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    tick(); // E10: grant C
    tick(); // E11
    checks++; if ({ifid_valid, ifid_pc4} !== {1'b1, 32'h10}) begin failures++; $display("FAIL rw_pre: got %b/%h want 1/00000010", ifid_valid, ifid_pc4); end
    slow = 1'b1;
    tick(); // E12: grant 10, response delayed
    br_taken = 1'b1; br_target = 32'h0000_0103;
    tick(); // E13: redirect while waiting
    br_taken = 1'b0;
    checks++; if ({ifid_valid, imem_req, pc} !== {1'b0, 1'b0, 32'h100}) begin failures++; $display("FAIL rw_redirect: got %b/%b/%h want 0/0/00000100", ifid_valid, imem_req, pc); end
    tick(); // E14: stale response dropped
    checks++; if ({ifid_valid, ifid_pc4} !== {1'b0, 32'h10}) begin failures++; $display("FAIL rw_dropped: got %b/%h want 0/00000010", ifid_valid, ifid_pc4); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL rw_new_addr: got %b/%h want 1/00000100", imem_req, imem_addr); end
    slow = 1'b0;
    tick(); // E15
    tick(); // E16
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h104, 32'hC0DE_0100}) begin failures++; $display("FAIL rw_target: got %b/%h/%h want 1/00000104/c0de0100", ifid_valid, ifid_pc4, ifid_instr); end
  endtask

  task automatic test_redirect_rvalid_stall();
    stall = 1'b1;
    tick(); // E17: grant 104 while IF/ID held
    checks++; if ({ifid_valid, imem_req} !== {1'b1, 1'b0}) begin failures++; $display("FAIL rs_held: got %b/%b want 1/0", ifid_valid, imem_req); end
    br_taken = 1'b1; br_target = 32'h0000_0200;
    tick(); // E18: redirect collides with rvalid under stall
    br_taken = 1'b0; stall = 1'b0;
    checks++; if ({ifid_valid, pc, ifid_pc4} !== {1'b0, 32'h200, 32'h104}) begin failures++; $display("FAIL rs_flush: got %b/%h/%h want 0/00000200/00000104", ifid_valid, pc, ifid_pc4); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL rs_req: got %b/%h want 1/00000200", imem_req, imem_addr); end
    tick(); // E19
    tick(); // E20
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h204, 32'hC0DE_0200}) begin failures++; $display("FAIL rs_target: got %b/%h/%h want 1/00000204/c0de0200", ifid_valid, ifid_pc4, ifid_instr); end
  endtask

  task automatic test_redirect_grant();
    br_taken = 1'b1; br_target = 32'h0000_0302;
    tick(); // E21: redirect coincides with grant of 204
    br_taken = 1'b0;
    checks++; if ({pc, imem_req, ifid_valid} !== {32'h300, 1'b0, 1'b0}) begin failures++; $display("FAIL rg_pc: got %h/%b/%b want 00000300/0/0", pc, imem_req, ifid_valid); end
    tick(); // E22: response for 204 is dropped
    checks++; if ({ifid_valid, ifid_pc4} !== {1'b0, 32'h204}) begin failures++; $display("FAIL rg_dropped: got %b/%h want 0/00000204", ifid_valid, ifid_pc4); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin failures++; $display("FAIL rg_req: got %b/%h want 1/00000300", imem_req, imem_addr); end
    tick(); // E23
    tick(); // E24
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h304, 32'hC0DE_0300}) begin failures++; $display("FAIL rg_target: got %b/%h/%h want 1/00000304/c0de0300", ifid_valid, ifid_pc4, ifid_instr); end
  endtask

  task automatic test_async_reset();
    slow = 1'b1;
    tick(); // E25: grant 304, now waiting
    checks++; if ({imem_req, pc} !== {1'b0, 32'h308}) begin failures++; $display("FAIL ar_pre: got %b/%h want 0/00000308", imem_req, pc); end
    rst_n = 1'b0;
    #1;
    checks++; if ({imem_req, pc} !== {1'b0, 32'h0}) begin failures++; $display("FAIL ar_req_pc: got %b/%h want 0/00000000", imem_req, pc); end
    checks++; if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL ar_ifid: got %b/%h/%h want 0/00000000/00000000", ifid_valid, ifid_instr, ifid_pc4); end
    #1;
    rst_n = 1'b1;
    tick(); // E26: restart, late rvalid arriving
    checks++; if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin failures++; $display("FAIL ar_restart: got %b/%h/%b want 1/00000000/0", imem_req, imem_addr, ifid_valid); end
    tick(); // E27: grant 0
    checks++; if ({pc, imem_req, ifid_valid} !== {32'h4, 1'b0, 1'b0}) begin failures++; $display("FAIL ar_late_ignored: got %h/%b/%b want 00000004/0/0", pc, imem_req, ifid_valid); end
    tick(); // E28
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL ar_wait: got %b want 0", ifid_valid); end
    tick(); // E29
    checks++; if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, 32'h4, 32'hC0DE_0000}) begin failures++; $display("FAIL ar_first: got %b/%h/%h want 1/00000004/c0de0000", ifid_valid, ifid_pc4, ifid_instr); end
    slow = 1'b0;
  endtask

  task automatic test_wrap();
    checks++; if ({req2, pc2} !== {1'b0, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wr_rst: got %b/%h want 0/fffffffc", req2, pc2); end
    rst2_n = 1'b1;
    tick(); // W1
    checks++; if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wr_first_addr: got %b/%h want 1/fffffffc", req2, addr2); end
    tick(); // W2: pc wraps
    checks++; if ({req2, pc2} !== {1'b0, 32'h0}) begin failures++; $display("FAIL wr_pc_wrap: got %b/%h want 0/00000000", req2, pc2); end
    tick(); // W3
    checks++; if ({v2, pc4_2, instr2} !== {1'b1, 32'h0, 32'hC0DE_FFFC}) begin failures++; $display("FAIL wr_ifid: got %b/%h/%h want 1/00000000/c0defffc", v2, pc4_2, instr2); end
    checks++; if ({req2, addr2} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wr_next_addr: got %b/%h want 1/00000000", req2, addr2); end
    tick(); // W4
    tick(); // W5
    checks++; if ({v2, pc4_2, instr2} !== {1'b1, 32'h4, 32'hC0DE_0000}) begin failures++; $display("FAIL wr_second: got %b/%h/%h want 1/00000004/c0de0000", v2, pc4_2, instr2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_redirect_grant();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
